// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, operand-select and ALU encodings, EX bubble constant
package cpu_pkg;

  localparam int DW = 16;
  localparam int RW = 3;

  localparam logic [1:0] OP_SEL_ZERO = 2'b00;
  localparam logic [1:0] OP_SEL_REG  = 2'b01;
  localparam logic [1:0] OP_SEL_PC   = 2'b10;
  localparam logic [1:0] OP_SEL_RSVD = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_PASS = 4'h9;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] op1_sel;
    logic [1:0] op2_sel;
    logic [3:0] alu_op;
  } ex_ctrl_t;

  // A bubble is a non-valid slot with every control bit cleared.
  localparam ex_ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [1:0] sanitize_sel(input logic [1:0] sel);
    return (sel == OP_SEL_RSVD) ? OP_SEL_ZERO : sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous active-high clear
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, flush, WB snoop and debug counters
module id_ex_pipe_reg #(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Stall_EX,
  input  logic          Flush_EX,
  input  logic          Valid_ID,
  input  logic [DW-1:0] PC_ID,
  input  logic [DW-1:0] Rout1_ID,
  input  logic [DW-1:0] Rout2_ID,
  input  logic [DW-1:0] Imm_ID,
  input  logic [RW-1:0] Rs1_ID,
  input  logic [RW-1:0] Rs2_ID,
  input  logic [RW-1:0] Rd_ID,
  input  logic [1:0]    Op1_Sel_ID,
  input  logic [1:0]    Op2_Sel_ID,
  input  logic [3:0]    ALU_Op_ID,
  input  logic          RegWrite_ID,
  input  logic          MemRead_ID,
  input  logic          MemWrite_ID,
  input  logic          WB_We,
  input  logic [RW-1:0] WB_Rd,
  input  logic [DW-1:0] WB_Data,
  output logic          Valid_EX,
  output logic [DW-1:0] PC_EX,
  output logic [DW-1:0] Rout1_EX,
  output logic [DW-1:0] Rout2_EX,
  output logic [DW-1:0] Imm_EX,
  output logic [RW-1:0] Rs1_EX,
  output logic [RW-1:0] Rs2_EX,
  output logic [RW-1:0] Rd_EX,
  output logic [1:0]    Op1_Sel_EX,
  output logic [1:0]    Op2_Sel_EX,
  output logic [3:0]    ALU_Op_EX,
  output logic          RegWrite_EX,
  output logic          MemRead_EX,
  output logic          MemWrite_EX,
  output logic [CW-1:0] Stall_Cnt,
  output logic [CW-1:0] Flush_Cnt
);

  import cpu_pkg::*;

  ex_ctrl_t      ctrl_q;
  logic [DW-1:0] pc_q;
  logic [DW-1:0] rout1_q;
  logic [DW-1:0] rout2_q;
  logic [DW-1:0] imm_q;
  logic [RW-1:0] rs1_q;
  logic [RW-1:0] rs2_q;
  logic [RW-1:0] rd_q;

  logic wb_live;
  logic hit_id1;
  logic hit_id2;
  logic hit_ex1;
  logic hit_ex2;

  // Register 0 is hard-wired to zero, so a write-back to it never bypasses.
  assign wb_live = WB_We && (WB_Rd != '0);
  assign hit_id1 = wb_live && (WB_Rd == Rs1_ID);
  assign hit_id2 = wb_live && (WB_Rd == Rs2_ID);
  assign hit_ex1 = wb_live && (WB_Rd == rs1_q);
  assign hit_ex2 = wb_live && (WB_Rd == rs2_q);

  always_ff @(posedge clk) begin
    if (rst || Flush_EX) begin
      ctrl_q  <= CTRL_BUBBLE;
      pc_q    <= '0;
      rout1_q <= '0;
      rout2_q <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (Stall_EX) begin
      // Held operands keep tracking write-backs; a held bubble stays all-zero.
      if (ctrl_q.valid) begin
        if (hit_ex1) rout1_q <= WB_Data;
        if (hit_ex2) rout2_q <= WB_Data;
      end
    end else if (Valid_ID) begin
      ctrl_q.valid     <= 1'b1;
      ctrl_q.reg_write <= RegWrite_ID;
      ctrl_q.mem_read  <= MemRead_ID;
      ctrl_q.mem_write <= MemWrite_ID;
      ctrl_q.op1_sel   <= sanitize_sel(Op1_Sel_ID);
      ctrl_q.op2_sel   <= sanitize_sel(Op2_Sel_ID);
      ctrl_q.alu_op    <= ALU_Op_ID;
      pc_q             <= PC_ID;
      rout1_q          <= hit_id1 ? WB_Data : Rout1_ID;
      rout2_q          <= hit_id2 ? WB_Data : Rout2_ID;
      imm_q            <= Imm_ID;
      rs1_q            <= Rs1_ID;
      rs2_q            <= Rs2_ID;
      rd_q             <= Rd_ID;
    end else begin
      ctrl_q  <= CTRL_BUBBLE;
      pc_q    <= '0;
      rout1_q <= '0;
      rout2_q <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end
  end

  sat_counter #(.CW(CW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (Stall_EX && !Flush_EX),
    .count (Stall_Cnt)
  );

  sat_counter #(.CW(CW)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (Flush_EX),
    .count (Flush_Cnt)
  );

  assign Valid_EX    = ctrl_q.valid;
  assign RegWrite_EX = ctrl_q.reg_write;
  assign MemRead_EX  = ctrl_q.mem_read;
  assign MemWrite_EX = ctrl_q.mem_write;
  assign Op1_Sel_EX  = ctrl_q.op1_sel;
  assign Op2_Sel_EX  = ctrl_q.op2_sel;
  assign ALU_Op_EX   = ctrl_q.alu_op;
  assign PC_EX       = pc_q;
  assign Rout1_EX    = rout1_q;
  assign Rout2_EX    = rout2_q;
  assign Imm_EX      = imm_q;
  assign Rs1_EX      = rs1_q;
  assign Rs2_EX      = rs2_q;
  assign Rd_EX       = rd_q;

endmodule
